display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Owns the 8-digit 7-segment indicator: an 8x4-bit digit buffer plus a decimal-point position.
//  Accepts digit-update commands from the calculator core through a valid/ready handshake.
//  Time-multiplexes the buffer onto the indicator/indicator_choice pins with a prescaled scan.
//  Replaces ad-hoc free-running index logic; it is the single sequencer of the display datapath.
// PARAMETERS
//  DIV    5000  clk cycles per digit slot; legal range 2..65535
//  BLANK  2     cycles at the start of each slot with all digits off (anti-ghosting); must be < DIV
// PORTS
//  clk              in   1  system clock, all logic on the rising edge
//  clear_n          in   1  asynchronous, active-low reset
//  cmd_valid        in   1  command present
//  cmd_ready        out  1  block can accept a command this cycle
//  cmd_op           in   2  00 CLEAR, 01 SHIFT_IN, 10 WRITE, 11 SET_DP
//  cmd_idx          in   3  digit index for WRITE/SET_DP; 0 = rightmost digit
//  cmd_value        in   4  hex digit for SHIFT_IN/WRITE
//  indicator        out  8  {dp,g,f,e,d,c,b,a}, 1 = segment lit, registered
//  indicator_choice out  8  digit select, one-hot active-low (bit i low = digit i on), registered
// BEHAVIOUR
//  Reset (async, clear_n=0):
//   - buffer=0, dp_en=0, dp_pos=0, state=IDLE, prescaler=0, scan_idx=0
//   - indicator=8'h00, indicator_choice=8'hFF
//   - cmd_ready=1 once clear_n deasserts
//  Handshake:
//   - Transfer when cmd_valid & cmd_ready.
//   - cmd_ready = (state==IDLE), combinational from the state register.
//   - Command fields are sampled only on a transfer.
//  Command FSM:
//   - IDLE
//     - WRITE: buf[cmd_idx] <= cmd_value at the transfer edge; stay IDLE.
//     - SHIFT_IN: buf[i] <= buf[i-1] for i = 7..1, buf[0] <= cmd_value, old buf[7] is lost;
//       dp_pos <= dp_pos+1 if dp_en and dp_pos<7, else dp_en <= 0. Stay IDLE.
//     - SET_DP: dp_pos <= cmd_idx, dp_en <= 1; stay IDLE.
//     - CLEAR: go to CLR with clr_cnt=0.
//   - CLR
//     - Each cycle: buf[clr_cnt] <= 0, clr_cnt++. dp_en <= 0 on entry.
//     - After writing entry 7 (8 cycles) go to IDLE.
//     - cmd_ready=0 throughout; the next command is accepted at the earliest 9 cycles after CLEAR.
//  Scan:
//   - Runs continuously in every state.
//   - Prescaler counts 0..DIV-1. On wrap, scan_idx increments mod 8 (7 -> 0).
//   - Registered outputs lag the prescaler/scan_idx by 1 cycle.
//   - Prescaler < BLANK: indicator_choice=8'hFF, indicator=8'h00.
//   - Otherwise: indicator_choice=~(1<<scan_idx);
//     indicator[6:0]=hexseg(buf[scan_idx]); indicator[7]=dp_en & (dp_pos==scan_idx).
//   - hexseg glyphs (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//     8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   - Buffer is read combinationally. An update to the entry being scanned appears on the pins
//     the cycle after its transfer edge, with no tearing within a cycle.
//   - Full refresh period = 8*DIV cycles.
//  Boundaries:
//   - Reset asserted mid-CLR aborts it; all state returns to reset values.
//   - CLEAR while scanning never stalls the scan.
//   - cmd_valid held high with cmd_ready=0 causes no action.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - Digit i shows indicator[6:0]=0 when buf[j]==0 for all j>=i, i>0, and !(dp_en && dp_pos>=i).
//   - Digit 0 is never blanked.
//   - indicator_choice is unchanged.
//  LEADING_ZERO_BLANK_EN undefined: every digit is always shown, including leading zeros.
// TESTING (DIV=8, BLANK=2)
//  1 Release reset, idle 64 cycles -> each digit selected in order 0..7; indicator=3F when
//    selected, 00 during each 2-cycle blank.
//  2 WRITE idx3 val 0xA, then watch slot 3 -> indicator=77, indicator_choice=F7.
//  3 SHIFT_IN 1,2,3 with no gaps -> buf[2:0]=1,2,3; cmd_ready stays 1; slot 0 shows 4F.
//  4 SET_DP idx0, then SHIFT_IN 5 -> dp lit on digit 1 only (slot 1 shows indicator bit7=1).
//  5 CLEAR with cmd_valid held and WRITE queued behind it -> cmd_ready low for exactly 8 cycles;
//    WRITE accepted on cycle 9; all other digits read 0.
//  6 Assert clear_n low during cycle 4 of CLR -> immediately indicator=00, indicator_choice=FF;
//    after release, cmd_ready=1 and the scan restarts at digit 0.
//  7 LEADING_ZERO_BLANK_EN defined, buffer=00000120 -> digits 7..3 dark, digits 2..0
//    show 06, 5B, 3F.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Owns the 8-digit 7-segment indicator: an 8x4-bit digit buffer plus a
//   decimal-point position, updated by valid/ready commands and scanned onto
//   the indicator pins by a prescaled time-multiplexer.
// Parameters
//   DIV    clk cycles per digit slot (2..65535)
//   BLANK  all-off cycles at the start of each slot (< DIV)
// Ports
//   clk              in   system clock, rising edge
//   clear_n          in   asynchronous active-low reset
//   cmd_valid        in   command present
//   cmd_ready        out  command can be accepted (combinational from state)
//   cmd_op           in   00 CLEAR, 01 SHIFT_IN, 10 WRITE, 11 SET_DP
//   cmd_idx          in   digit index for WRITE/SET_DP, 0 = rightmost
//   cmd_value        in   hex digit for SHIFT_IN/WRITE
//   indicator        out  {dp,g,f,e,d,c,b,a}, 1 = lit, registered
//   indicator_choice out  one-hot active-low digit select, registered
// Configuration
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (above digit 0
//                          and above the decimal point) are shown dark.

module display_scan_ctrl #(
  parameter int unsigned DIV   = 5000,
  parameter int unsigned BLANK = 2
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_idx,
  input  logic [3:0] cmd_value,
  output logic [7:0] indicator,
  output logic [7:0] indicator_choice
);

  localparam int unsigned PW = 16;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_SETDP = 2'b11;

  typedef enum logic {ST_IDLE, ST_CLR} state_t;

  state_t        r_state;
  logic [3:0]    r_buf [8];
  logic          r_dp_en;
  logic [2:0]    r_dp_pos;
  logic [2:0]    r_clr_cnt;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_scan_idx;
  logic [7:0]    r_ind;
  logic [7:0]    r_choice;

  logic          w_xfer;
  logic [6:0]    w_seg;
  logic          w_dp;

  assign cmd_ready        = (r_state == ST_IDLE);
  assign w_xfer           = cmd_valid & cmd_ready;
  assign indicator        = r_ind;
  assign indicator_choice = r_choice;

  function automatic logic [6:0] hexseg(input logic [3:0] d);
    case (d)
      4'h0: hexseg = 7'h3F;
      4'h1: hexseg = 7'h06;
      4'h2: hexseg = 7'h5B;
      4'h3: hexseg = 7'h4F;
      4'h4: hexseg = 7'h66;
      4'h5: hexseg = 7'h6D;
      4'h6: hexseg = 7'h7D;
      4'h7: hexseg = 7'h07;
      4'h8: hexseg = 7'h7F;
      4'h9: hexseg = 7'h6F;
      4'hA: hexseg = 7'h77;
      4'hB: hexseg = 7'h7C;
      4'hC: hexseg = 7'h39;
      4'hD: hexseg = 7'h5E;
      4'hE: hexseg = 7'h79;
      default: hexseg = 7'h71;
    endcase
  endfunction

  // Command FSM: buffer and decimal-point updates, 8-cycle sequential clear
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= ST_IDLE;
      r_dp_en   <= 1'b0;
      r_dp_pos  <= 3'd0;
      r_clr_cnt <= 3'd0;
      for (int i = 0; i < 8; i++) r_buf[i] <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            case (cmd_op)
              OP_WRITE: r_buf[cmd_idx] <= cmd_value;
              OP_SHIFT: begin
                for (int i = 7; i >= 1; i--) r_buf[i] <= r_buf[i-1];
                r_buf[0] <= cmd_value;
                // dp follows its digit; it falls off the left edge with it
                if (r_dp_en && (r_dp_pos < 3'd7)) r_dp_pos <= r_dp_pos + 3'd1;
                else                               r_dp_en  <= 1'b0;
              end
              OP_SETDP: begin
                r_dp_pos <= cmd_idx;
                r_dp_en  <= 1'b1;
              end
              default: begin
                r_state   <= ST_CLR;
                r_clr_cnt <= 3'd0;
                r_dp_en   <= 1'b0;
              end
            endcase
          end
        end
        default: begin
          r_buf[r_clr_cnt] <= 4'd0;
          r_clr_cnt        <= r_clr_cnt + 3'd1;
          if (r_clr_cnt == 3'd7) r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] w_blank;

  // Digit i is dark when it and everything left of it are zero and no dp sits at or left of it
  always_comb begin
    logic w_zero_run;
    w_blank    = 8'd0;
    w_zero_run = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_buf[i] == 4'd0);
      w_blank[i] = w_zero_run & ~(r_dp_en & (r_dp_pos >= 3'(i)));
    end
  end

  assign w_seg = w_blank[r_scan_idx] ? 7'h00 : hexseg(r_buf[r_scan_idx]);
`else
  assign w_seg = hexseg(r_buf[r_scan_idx]);
`endif

  assign w_dp = r_dp_en & (r_dp_pos == r_scan_idx);

  // Scan: free-running prescaler and digit index, outputs registered one cycle behind
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_presc    <= '0;
      r_scan_idx <= 3'd0;
      r_ind      <= 8'h00;
      r_choice   <= 8'hFF;
    end else begin
      if (r_presc == PW'(DIV - 1)) begin
        r_presc    <= '0;
        r_scan_idx <= r_scan_idx + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (r_presc < PW'(BLANK)) begin
        r_ind    <= 8'h00;
        r_choice <= 8'hFF;
      end else begin
        r_ind    <= {w_dp, w_seg};
        r_choice <= ~(8'd1 << r_scan_idx);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl with DIV=8, BLANK=2. A cycle counter
//   restarted by reset predicts which slot/phase the registered outputs show.

module tb_display_scan_ctrl;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_idx = 3'd0;
  logic [3:0] cmd_value = 4'd0;
  logic [7:0] indicator;
  logic [7:0] indicator_choice;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk              (clk),
    .clear_n          (clear_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_idx          (cmd_idx),
    .cmd_value        (cmd_value),
    .indicator        (indicator),
    .indicator_choice (indicator_choice)
  );

  always #5 clk = ~clk;

  // Edges since reset release; after edge k the pins reflect scan cycle k-1
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Caller is at a negedge; returns at the negedge after the transfer edge, valid left high
  task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] val);
    int n;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_value = val;
    cmd_valid = 1'b1;
    for (n = 0; n < 32; n++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    n_vec++;
    if (n == 32) begin
      $display("FAIL send_ready: cmd_ready stayed %b, required 1", cmd_ready);
      n_err++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for a visible cycle of the given slot and check both output buses
  task automatic wait_show(input int slot, input logic [7:0] exp_ind, input string name);
    logic [7:0] exp_ch;
    int c;
    int n;
    exp_ch = ~(8'd1 << slot);
    for (n = 0; n < 160; n++) begin
      @(posedge clk);
      #1;
      c = cyc - 1;
      if ((c % DIV) >= BLANK && ((c / DIV) % 8) == slot) break;
    end
    n_vec++;
    if (n == 160) begin
      $display("FAIL %s_timeout: slot %0d never reached", name, slot);
      n_err++;
    end else if (indicator !== exp_ind || indicator_choice !== exp_ch) begin
      $display("FAIL %s: indicator=%h choice=%h, required indicator=%h choice=%h",
               name, indicator, indicator_choice, exp_ind, exp_ch);
      n_err++;
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (indicator !== 8'h00 || indicator_choice !== 8'hFF) begin
      $display("FAIL reset_outputs: indicator=%h choice=%h, required 00/FF", indicator, indicator_choice);
      n_err++;
    end
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
      n_err++;
    end
  endtask

  task automatic test_idle_scan();
    logic [7:0] e_ind, e_ch;
    int c;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      c = k - 1;
      if ((c % 8) < 2) begin
        e_ind = 8'h00;
        e_ch  = 8'hFF;
      end else begin
        e_ind = (LZB && (c / 8) != 0) ? 8'h00 : 8'h3F;
        e_ch  = ~(8'd1 << (c / 8));
      end
      n_vec++;
      if (indicator !== e_ind || indicator_choice !== e_ch) begin
        $display("FAIL idle_scan[%0d]: indicator=%h choice=%h, required %h/%h",
                 c, indicator, indicator_choice, e_ind, e_ch);
        n_err++;
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    send(2'b10, 3'd3, 4'hA);
    cmd_valid = 1'b0;
    wait_show(3, 8'h77, "write_slot3");
    wait_show(0, 8'h3F, "write_slot0");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int v = 1; v <= 3; v++) begin
      n_vec++;
      if (cmd_ready !== 1'b1) begin
        $display("FAIL b2b_ready[%0d]: cmd_ready=%b, required 1", v, cmd_ready);
        n_err++;
      end
      send(2'b01, 3'd0, 4'(v));
    end
    cmd_valid = 1'b0;
    // buf = 0A00_0123
    wait_show(0, 8'h4F, "b2b_slot0");
    wait_show(1, 8'h5B, "b2b_slot1");
    wait_show(2, 8'h06, "b2b_slot2");
    wait_show(6, 8'h77, "b2b_slot6");
    wait_show(3, 8'h3F, "b2b_slot3");
  endtask

  task automatic test_dp();
    @(negedge clk);
    send(2'b11, 3'd0, 4'h0);
    send(2'b01, 3'd0, 4'h5);
    cmd_valid = 1'b0;
    // buf = A000_1235, dp on digit 1
    wait_show(1, 8'hCF, "dp_slot1");
    wait_show(0, 8'h6D, "dp_slot0");
    wait_show(7, 8'h77, "dp_slot7");
    @(negedge clk);
    send(2'b11, 3'd7, 4'h0);
    send(2'b01, 3'd0, 4'h0);
    cmd_valid = 1'b0;
    // buf = 0001_2350, dp shifted off the left and disabled, old A lost
    wait_show(7, LZB ? 8'h00 : 8'h3F, "dp_off_slot7");
    wait_show(4, 8'h06, "dp_off_slot4");
    wait_show(1, 8'h6D, "dp_off_slot1");
  endtask

  task automatic test_clear_queued();
    int low;
    @(negedge clk);
    send(2'b00, 3'd0, 4'h0);
    cmd_op    = 2'b10;
    cmd_idx   = 3'd5;
    cmd_value = 4'h9;
    low = 0;
    while (!cmd_ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    n_vec++;
    if (low !== 8) begin
      $display("FAIL clear_busy_cycles: cmd_ready low %0d cycles, required 8", low);
      n_err++;
    end
    send(2'b10, 3'd5, 4'h9);
    cmd_valid = 1'b0;
    // buf = 0090_0000
    wait_show(5, 8'h6F, "clear_slot5");
    wait_show(0, 8'h3F, "clear_slot0");
    wait_show(2, 8'h3F, "clear_slot2");
    wait_show(6, LZB ? 8'h00 : 8'h3F, "clear_slot6");
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    send(2'b00, 3'd0, 4'h0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear_n = 1'b0;
    #1;
    n_vec++;
    if (indicator !== 8'h00 || indicator_choice !== 8'hFF) begin
      $display("FAIL midclr_reset: indicator=%h choice=%h, required 00/FF", indicator, indicator_choice);
      n_err++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL midclr_ready: cmd_ready=%b, required 1", cmd_ready);
      n_err++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (indicator !== 8'h3F || indicator_choice !== 8'hFE) begin
      $display("FAIL midclr_restart: indicator=%h choice=%h, required 3F/FE", indicator, indicator_choice);
      n_err++;
    end
    // digit 5 was not yet reached by the aborted clear; reset must zero it
    wait_show(5, LZB ? 8'h00 : 8'h3F, "midclr_slot5");
  endtask

  task automatic test_leading_zero();
    @(negedge clk);
    send(2'b10, 3'd2, 4'h1);
    send(2'b10, 3'd1, 4'h2);
    send(2'b10, 3'd0, 4'h0);
    cmd_valid = 1'b0;
    // buf = 0000_0120
    wait_show(7, LZB ? 8'h00 : 8'h3F, "lz_slot7");
    wait_show(3, LZB ? 8'h00 : 8'h3F, "lz_slot3");
    wait_show(2, 8'h06, "lz_slot2");
    wait_show(1, 8'h5B, "lz_slot1");
    wait_show(0, 8'h3F, "lz_slot0");
    @(negedge clk);
    send(2'b11, 3'd4, 4'h0);
    cmd_valid = 1'b0;
    wait_show(4, 8'hBF, "lz_dp_slot4");
    wait_show(3, 8'h3F, "lz_dp_slot3");
    wait_show(5, LZB ? 8'h00 : 8'h3F, "lz_dp_slot5");
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write();
    test_back_to_back();
    test_dp();
    test_clear_queued();
    test_reset_mid_clear();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
